rf_writeback_unit: RTL and testbench
====================================

Name: rf_writeback_unit

Overview:
- Producer side of the register-file write port: `write_enable`, `write_addr` (5b), `write_data` (32b).
- Merges two result sources into one registered regfile write per cycle:
  - single-cycle ALU results, which have priority and are never stalled;
  - memory/load results, which use a valid/ready handshake and are buffered in a small FIFO.
- Provides decode-stage forwarding and pending-write hazard flags against both regfile read addresses.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- FIFO_DEPTH, 4, memory-result buffer entries (power of two, ≥2)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- alu_valid  input  1  ALU result present this cycle
- alu_rd  input  ADDR_W  ALU destination register
- alu_data  input  DATA_W  ALU result
- mem_valid  input  1  memory result offered
- mem_ready  output  1  unit accepts memory result this cycle
- mem_rd  input  ADDR_W  memory destination register
- mem_data  input  DATA_W  memory result
- write_enable  output  1  regfile write strobe (registered)
- write_addr  output  ADDR_W  regfile write address (registered)
- write_data  output  DATA_W  regfile write data (registered)
- read_addr_1  input  ADDR_W  decode read address, port 1
- read_addr_2  input  ADDR_W  decode read address, port 2
- fwd_valid_1  output  1  in-flight write matches read_addr_1
- fwd_data_1  output  DATA_W  forwarded data, port 1
- fwd_valid_2  output  1  in-flight write matches read_addr_2
- fwd_data_2  output  DATA_W  forwarded data, port 2
- pending_1  output  1  live buffered write to read_addr_1 (decode must stall)
- pending_2  output  1  live buffered write to read_addr_2

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - write_enable=0, write_addr=0, write_data=0.
  - FIFO emptied and all entry live bits cleared.
  - Outputs after reset: mem_ready=1, fwd_valid_*=0, pending_*=0.
  - rst overrides every other input in that cycle, including a push or pop in progress.
- Accept:
  - mem_ready = !full. full is derived from the registered occupancy count only; a pop in the same cycle does not free a slot.
  - Handshake occurs when mem_valid & mem_ready. The entry {rd, data, live=1} is pushed.
  - mem_rd==0 is handshaken but not pushed (dropped).
- ALU request: alu_valid & alu_rd!=0. alu_rd==0 is treated as no request.
- Arbitration at each edge (fixed priority):
  - If an ALU request is present: load the output register with {1, alu_rd, alu_data}. No FIFO pop.
  - Else if the FIFO is non-empty: pop the head and load {head.live, head.rd, head.data}. A killed head produces write_enable=0.
  - Else: write_enable<=0, and write_addr/write_data hold their previous values.
- Ordering rule:
  - Within a cycle, the ALU result is younger than every buffered and incoming memory result.
  - On an ALU request, every FIFO entry with rd==alu_rd has its live bit cleared (killed).
  - A memory result pushed in the same cycle with the same rd is pushed already killed.
- Latency:
  - Inputs sampled at edge N drive write_* during cycle N..N+1; the regfile commits at edge N+1.
  - Memory results see additional delay of one cycle per queued entry ahead, plus every cycle the ALU wins arbitration.
- Push and pop in the same cycle are both legal; occupancy is unchanged. Pointers wrap modulo FIFO_DEPTH.
- Forwarding (combinational):
  - fwd_valid_n = write_enable & write_addr==read_addr_n & read_addr_n!=0.
  - fwd_data_n = write_data when fwd_valid_n, else 0.
- Pending (combinational): pending_n = OR over occupied, live FIFO entries of (rd==read_addr_n), gated by read_addr_n!=0.
- Starvation: continuous ALU requests may starve the FIFO indefinitely. This is permitted; mem_ready falls when the FIFO is full.

Decomposition:
- Shared package `riscv_pkg`: DATA_W, ADDR_W, REG_ZERO (5'd0), and the writeback-entry struct/packing {live, rd, data}.
- One sub-module: `rf_wb_fifo`.
  - Circular buffer with push, pop, full, empty and count.
  - Per-entry kill input (kill_en, kill_rd).
  - Parallel compare ports for the two pending lookups.
- Arbitration, output register and forwarding logic stay in the top module.

Test Plan:
1. After reset: write_enable=0, mem_ready=1, pending_*=0. Then alu_valid=1, rd=1, data=0x12345678 for one cycle → next cycle write_enable=1, write_addr=1, write_data=0x12345678; fwd_valid_1=1 when read_addr_1=1.
2. Four memory pushes with rd=2..5, data=0xA0..0xA3, and no ALU traffic.
   - mem_ready stays 1.
   - Writes appear in order rd 2,3,4,5 on four consecutive cycles, starting one cycle after the first push.
3. Hold the ALU busy (rd=6) while pushing five memory results → the fifth sees mem_ready=0 until the ALU goes idle.
   - Then drain in FIFO order.
   - pending_1=1 for read_addr_1=3 while the rd=3 entry is queued.
4. Queue a memory result rd=7, data=0xDEAD. The same cycle, issue ALU rd=7, data=0xCAFEBABE.
   - Regfile sees only 0xCAFEBABE to rd 7.
   - The killed pop yields write_enable=0.
   - pending for 7 drops immediately after the kill.
5. alu_rd=0 and a memory result with rd=0, data=0xDEADBEEF → no write_enable pulse for address 0; mem handshake completes; fwd_valid=0 for read_addr=0.
6. Assert rst with three entries queued and write_enable=1 → next cycle everything is cleared and no queued write is ever issued afterwards.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared register-file definitions for the writeback path.
package riscv_pkg;

   localparam int DATA_W     = 32;
   localparam int ADDR_W     = 5;
   localparam int FIFO_DEPTH = 4;

   // x0 is hard-wired to zero: writes to it are discarded.
   localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

   // One buffered writeback: live=0 means a younger write has superseded it.
   typedef struct packed {
      logic              live;
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

   function automatic wb_entry_t make_entry(input logic              live,
                                            input logic [ADDR_W-1:0] rd,
                                            input logic [DATA_W-1:0] data);
      wb_entry_t e;
      e.live = live;
      e.rd   = rd;
      e.data = data;
      return e;
   endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Circular buffer of pending memory writebacks with per-entry kill and
// parallel destination-register lookups for decode hazard detection.
module rf_wb_fifo
   import riscv_pkg::*;
#(
   parameter int DATA_W = riscv_pkg::DATA_W,
   parameter int ADDR_W = riscv_pkg::ADDR_W,
   parameter int DEPTH  = riscv_pkg::FIFO_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic                     push_live_i,
   input  logic [ADDR_W-1:0]        push_rd_i,
   input  logic [DATA_W-1:0]        push_data_i,
   input  logic                     pop_i,
   input  logic                     kill_en_i,
   input  logic [ADDR_W-1:0]        kill_rd_i,
   input  logic [ADDR_W-1:0]        lookup_rd_1_i,
   input  logic [ADDR_W-1:0]        lookup_rd_2_i,
   output logic                     head_live_o,
   output logic [ADDR_W-1:0]        head_rd_o,
   output logic [DATA_W-1:0]        head_data_o,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     lookup_hit_1_o,
   output logic                     lookup_hit_2_o
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]    count_q, count_d;
   logic [DEPTH-1:0]  live_q;
   logic [DEPTH-1:0]  occupied;
   logic [DEPTH-1:0]  hit_1;
   logic [DEPTH-1:0]  hit_2;
   logic [ADDR_W-1:0] rd_q   [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic              empty;

   assign empty  = (count_q == '0);
   assign full_o = (count_q == (PTR_W+1)'(DEPTH));
   assign count_o = count_q;

   // A slot is occupied when its distance from the head is below the count.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [PTR_W-1:0] offset;
         assign offset       = PTR_W'(gi) - rd_ptr_q;
         assign occupied[gi] = ({1'b0, offset} < count_q);
         assign hit_1[gi]    = occupied[gi] & live_q[gi] & (rd_q[gi] == lookup_rd_1_i);
         assign hit_2[gi]    = occupied[gi] & live_q[gi] & (rd_q[gi] == lookup_rd_2_i);
      end
   endgenerate

   assign lookup_hit_1_o = |hit_1;
   assign lookup_hit_2_o = |hit_2;

   assign head_live_o = live_q[rd_ptr_q] & ~empty;
   assign head_rd_o   = rd_q[rd_ptr_q];
   assign head_data_o = data_q[rd_ptr_q];

   // Pointer and occupancy next-state; caller never pushes when full or pops when empty.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointers, count and live bits; a kill clears matching occupied entries.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         live_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         for (int i = 0; i < DEPTH; i++) begin
            if (push_i && (wr_ptr_q == PTR_W'(i))) begin
               live_q[i] <= push_live_i;
            end else if (kill_en_i && occupied[i] && (rd_q[i] == kill_rd_i)) begin
               live_q[i] <= 1'b0;
            end
         end
      end
   end

   // Payload storage; contents of free slots are don't-care so no reset is needed.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (push_i && (wr_ptr_q == PTR_W'(i))) begin
            rd_q[i]   <= push_rd_i;
            data_q[i] <= push_data_i;
         end
      end
   end

endmodule

// File: rtl/rf_writeback_unit.sv
// Register-file write port producer: merges never-stalled ALU results with
// buffered memory results, and exposes forwarding and pending-hazard flags.
module rf_writeback_unit
   import riscv_pkg::*;
#(
   parameter int DATA_W     = riscv_pkg::DATA_W,
   parameter int ADDR_W     = riscv_pkg::ADDR_W,
   parameter int FIFO_DEPTH = riscv_pkg::FIFO_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_valid,
   input  logic [ADDR_W-1:0] alu_rd,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic [ADDR_W-1:0] mem_rd,
   input  logic [DATA_W-1:0] mem_data,
   output logic              write_enable,
   output logic [ADDR_W-1:0] write_addr,
   output logic [DATA_W-1:0] write_data,
   input  logic [ADDR_W-1:0] read_addr_1,
   input  logic [ADDR_W-1:0] read_addr_2,
   output logic              fwd_valid_1,
   output logic [DATA_W-1:0] fwd_data_1,
   output logic              fwd_valid_2,
   output logic [DATA_W-1:0] fwd_data_2,
   output logic              pending_1,
   output logic              pending_2
);

   localparam logic [ADDR_W-1:0] RD_ZERO = ADDR_W'(REG_ZERO);

   logic                           alu_req;
   logic                           mem_hs;
   logic                           fifo_push;
   logic                           fifo_push_live;
   logic                           fifo_pop;
   logic                           fifo_full;
   logic [$clog2(FIFO_DEPTH):0]    fifo_count;
   logic                           head_live;
   logic [ADDR_W-1:0]              head_rd;
   logic [DATA_W-1:0]              head_data;
   logic                           hit_1;
   logic                           hit_2;

   logic              we_q, we_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   // Writes to x0 are no-ops on both sources.
   assign alu_req   = alu_valid & (alu_rd != RD_ZERO);
   assign mem_ready = ~fifo_full;
   assign mem_hs    = mem_valid & mem_ready;
   assign fifo_push = mem_hs & (mem_rd != RD_ZERO);
   // The ALU result is younger than a same-cycle memory result, so that one is born dead.
   assign fifo_push_live = ~(alu_req & (mem_rd == alu_rd));
   assign fifo_pop  = ~alu_req & (fifo_count != '0);

   rf_wb_fifo #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk            (clk),
      .rst            (rst),
      .push_i         (fifo_push),
      .push_live_i    (fifo_push_live),
      .push_rd_i      (mem_rd),
      .push_data_i    (mem_data),
      .pop_i          (fifo_pop),
      .kill_en_i      (alu_req),
      .kill_rd_i      (alu_rd),
      .lookup_rd_1_i  (read_addr_1),
      .lookup_rd_2_i  (read_addr_2),
      .head_live_o    (head_live),
      .head_rd_o      (head_rd),
      .head_data_o    (head_data),
      .full_o         (fifo_full),
      .count_o        (fifo_count),
      .lookup_hit_1_o (hit_1),
      .lookup_hit_2_o (hit_2)
   );

   // Fixed-priority arbitration: ALU, then FIFO head, else idle with held address/data.
   always_comb begin
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      if (alu_req) begin
         we_d    = 1'b1;
         waddr_d = alu_rd;
         wdata_d = alu_data;
      end else if (fifo_pop) begin
         we_d    = head_live;
         waddr_d = head_rd;
         wdata_d = head_data;
      end
   end

   // Registered regfile write port.
   always_ff @(posedge clk) begin
      if (rst) begin
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   assign write_enable = we_q;
   assign write_addr   = waddr_q;
   assign write_data   = wdata_q;

   // Forward the in-flight write to decode; x0 never forwards.
   always_comb begin
      fwd_valid_1 = we_q & (waddr_q == read_addr_1) & (read_addr_1 != RD_ZERO);
      fwd_valid_2 = we_q & (waddr_q == read_addr_2) & (read_addr_2 != RD_ZERO);
      fwd_data_1  = fwd_valid_1 ? wdata_q : '0;
      fwd_data_2  = fwd_valid_2 ? wdata_q : '0;
   end

   assign pending_1 = hit_1 & (read_addr_1 != RD_ZERO);
   assign pending_2 = hit_2 & (read_addr_2 != RD_ZERO);

endmodule

// File: tb/tb_rf_writeback_unit.sv
// Directed bench for rf_writeback_unit.
module tb_rf_writeback_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        mem_valid;
   logic        mem_ready;
   logic [4:0]  mem_rd;
   logic [31:0] mem_data;
   logic        write_enable;
   logic [4:0]  write_addr;
   logic [31:0] write_data;
   logic [4:0]  read_addr_1;
   logic [4:0]  read_addr_2;
   logic        fwd_valid_1;
   logic [31:0] fwd_data_1;
   logic        fwd_valid_2;
   logic [31:0] fwd_data_2;
   logic        pending_1;
   logic        pending_2;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   rf_writeback_unit dut (
      .clk          (clk),
      .rst          (rst),
      .alu_valid    (alu_valid),
      .alu_rd       (alu_rd),
      .alu_data     (alu_data),
      .mem_valid    (mem_valid),
      .mem_ready    (mem_ready),
      .mem_rd       (mem_rd),
      .mem_data     (mem_data),
      .write_enable (write_enable),
      .write_addr   (write_addr),
      .write_data   (write_data),
      .read_addr_1  (read_addr_1),
      .read_addr_2  (read_addr_2),
      .fwd_valid_1  (fwd_valid_1),
      .fwd_data_1   (fwd_data_1),
      .fwd_valid_2  (fwd_valid_2),
      .fwd_data_2   (fwd_data_2),
      .pending_1    (pending_1),
      .pending_2    (pending_2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
      if (obs === exp) $display("ok   %-18s = 0x%08h", tag, obs);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_wr(input string tag, input logic [4:0] a, input logic [31:0] d);
      chk({tag, ".we"},   {31'd0, write_enable}, 32'd1);
      chk({tag, ".addr"}, {27'd0, write_addr}, {27'd0, a});
      chk({tag, ".data"}, write_data, d);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench timed out");
   end

   initial begin
      rst = 1'b1; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
      read_addr_1 = '0; read_addr_2 = '0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      // 1: reset state, then a single ALU write and forwarding
      chk("rst.we",        {31'd0, write_enable}, 32'd0);
      chk("rst.addr",      {27'd0, write_addr}, 32'd0);
      chk("rst.data",      write_data, 32'd0);
      chk("rst.mem_ready", {31'd0, mem_ready}, 32'd1);
      chk("rst.pending_1", {31'd0, pending_1}, 32'd0);
      chk("rst.pending_2", {31'd0, pending_2}, 32'd0);
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1234_5678;
      tick();
      alu_valid = 1'b0; read_addr_1 = 5'd1; read_addr_2 = 5'd2;
      #1;
      chk_wr("t1.alu", 5'd1, 32'h1234_5678);
      chk("t1.fwd_valid_1", {31'd0, fwd_valid_1}, 32'd1);
      chk("t1.fwd_data_1",  fwd_data_1, 32'h1234_5678);
      chk("t1.fwd_valid_2", {31'd0, fwd_valid_2}, 32'd0);
      chk("t1.fwd_data_2",  fwd_data_2, 32'd0);
      tick();
      chk("t1.idle.we",   {31'd0, write_enable}, 32'd0);
      chk("t1.idle.addr", {27'd0, write_addr}, 32'd1);
      chk("t1.idle.fwd",  {31'd0, fwd_valid_1}, 32'd0);

      // 2: four memory results, no ALU traffic
      mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'hA0;
      #1 chk("t2.ready0", {31'd0, mem_ready}, 32'd1);
      tick();
      chk("t2.we_after_push", {31'd0, write_enable}, 32'd0);
      mem_rd = 5'd3; mem_data = 32'hA1;
      #1 chk("t2.ready1", {31'd0, mem_ready}, 32'd1);
      tick();
      chk_wr("t2.w2", 5'd2, 32'hA0);
      mem_rd = 5'd4; mem_data = 32'hA2;
      #1 chk("t2.ready2", {31'd0, mem_ready}, 32'd1);
      tick();
      chk_wr("t2.w3", 5'd3, 32'hA1);
      mem_rd = 5'd5; mem_data = 32'hA3;
      #1 chk("t2.ready3", {31'd0, mem_ready}, 32'd1);
      tick();
      chk_wr("t2.w4", 5'd4, 32'hA2);
      mem_valid = 1'b0;
      tick();
      chk_wr("t2.w5", 5'd5, 32'hA3);
      tick();
      chk("t2.drained.we", {31'd0, write_enable}, 32'd0);

      // 3: ALU busy while five memory results arrive
      alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h600;
      mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'hB0;
      #1 chk("t3.ready0", {31'd0, mem_ready}, 32'd1);
      tick();
      chk_wr("t3.alu0", 5'd6, 32'h600);
      mem_rd = 5'd3; mem_data = 32'hB1;
      tick();
      mem_rd = 5'd4; mem_data = 32'hB2;
      tick();
      mem_rd = 5'd5; mem_data = 32'hB3;
      tick();
      mem_rd = 5'd8; mem_data = 32'hB4;
      read_addr_1 = 5'd3; read_addr_2 = 5'd5;
      #1;
      chk("t3.full.ready",   {31'd0, mem_ready}, 32'd0);
      chk("t3.pending_1",    {31'd0, pending_1}, 32'd1);
      chk("t3.pending_2",    {31'd0, pending_2}, 32'd1);
      chk("t3.fwd_valid_1",  {31'd0, fwd_valid_1}, 32'd0);
      tick();
      chk_wr("t3.alu4", 5'd6, 32'h600);
      chk("t3.stall.ready", {31'd0, mem_ready}, 32'd0);
      alu_valid = 1'b0;
      #1 chk("t3.popcycle.ready", {31'd0, mem_ready}, 32'd0);
      tick();
      chk_wr("t3.m2", 5'd2, 32'hB0);
      chk("t3.m2.pending_1", {31'd0, pending_1}, 32'd1);
      chk("t3.m2.ready",     {31'd0, mem_ready}, 32'd1);
      tick();
      chk_wr("t3.m3", 5'd3, 32'hB1);
      chk("t3.m3.pending_1", {31'd0, pending_1}, 32'd0);
      mem_valid = 1'b0;
      tick();
      chk_wr("t3.m4", 5'd4, 32'hB2);
      tick();
      chk_wr("t3.m5", 5'd5, 32'hB3);
      tick();
      chk_wr("t3.m8", 5'd8, 32'hB4);
      tick();
      chk("t3.drained.we", {31'd0, write_enable}, 32'd0);

      // 4: ALU write to rd7 kills a queued memory result
      mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'hDEAD;
      tick();
      mem_valid = 1'b0;
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hCAFE_BABE;
      read_addr_1 = 5'd7; read_addr_2 = 5'd0;
      #1 chk("t4.pending_pre", {31'd0, pending_1}, 32'd1);
      tick();
      chk_wr("t4.alu7", 5'd7, 32'hCAFE_BABE);
      chk("t4.pending_post", {31'd0, pending_1}, 32'd0);
      chk("t4.fwd_data_1",   fwd_data_1, 32'hCAFE_BABE);
      alu_valid = 1'b0;
      tick();
      chk("t4.killed.we",  {31'd0, write_enable}, 32'd0);
      chk("t4.killed.fwd", {31'd0, fwd_valid_1}, 32'd0);
      chk("t4.killed.fd",  fwd_data_1, 32'd0);
      // same-cycle collision: the incoming memory result is pushed dead
      mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h99;
      alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h1111;
      read_addr_2 = 5'd9;
      tick();
      chk_wr("t4.alu9", 5'd9, 32'h1111);
      chk("t4.col.pending_2", {31'd0, pending_2}, 32'd0);
      chk("t4.col.fwd_2",     {31'd0, fwd_valid_2}, 32'd1);
      mem_valid = 1'b0; alu_valid = 1'b0;
      tick();
      chk("t4.col.killed.we", {31'd0, write_enable}, 32'd0);

      // 5: rd=0 on both sources
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
      mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hDEAD_BEEF;
      read_addr_1 = 5'd0; read_addr_2 = 5'd0;
      #1 chk("t5.ready", {31'd0, mem_ready}, 32'd1);
      tick();
      chk("t5.we0",        {31'd0, write_enable}, 32'd0);
      chk("t5.fwd_valid",  {31'd0, fwd_valid_1}, 32'd0);
      chk("t5.pending",    {31'd0, pending_1}, 32'd0);
      alu_valid = 1'b0; mem_valid = 1'b0;
      tick();
      chk("t5.we1",        {31'd0, write_enable}, 32'd0);
      chk("t5.ready_post", {31'd0, mem_ready}, 32'd1);

      // 6: reset with three entries queued and a write in flight
      alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA10;
      mem_valid = 1'b1; mem_rd = 5'd11; mem_data = 32'h11;
      tick();
      mem_rd = 5'd12; mem_data = 32'h12;
      tick();
      mem_rd = 5'd13; mem_data = 32'h13;
      tick();
      mem_rd = 5'd14; mem_data = 32'h14;
      read_addr_1 = 5'd12; read_addr_2 = 5'd13;
      #1;
      chk("t6.pre.pending_1", {31'd0, pending_1}, 32'd1);
      chk_wr("t6.pre", 5'd10, 32'hA10);
      rst = 1'b1;
      tick();
      rst = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
      #1;
      chk("t6.we",        {31'd0, write_enable}, 32'd0);
      chk("t6.addr",      {27'd0, write_addr}, 32'd0);
      chk("t6.data",      write_data, 32'd0);
      chk("t6.mem_ready", {31'd0, mem_ready}, 32'd1);
      chk("t6.pending_1", {31'd0, pending_1}, 32'd0);
      chk("t6.pending_2", {31'd0, pending_2}, 32'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk($sformatf("t6.quiet%0d.we", i), {31'd0, write_enable}, 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
